// File: rtl/qgate_pair_pipe.sv
// qgate_pair_pipe: two-stage handshaked H/X/Z/S gate engine on one amplitude pair.
// Define QGATE_SAT_EN to saturate results on narrowing instead of wrapping.
module qgate_pair_pipe #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int INV_SQRT2 = 46341,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       gate_sel,
    input  logic [WIDTH-1:0] a0_re,
    input  logic [WIDTH-1:0] a0_im,
    input  logic [WIDTH-1:0] a1_re,
    input  logic [WIDTH-1:0] a1_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b0_re,
    output logic [WIDTH-1:0] b0_im,
    output logic [WIDTH-1:0] b1_re,
    output logic [WIDTH-1:0] b1_im,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW = 2 * WIDTH + 2;

    localparam logic [1:0] G_H = 2'b00;
    localparam logic [1:0] G_X = 2'b01;
    localparam logic [1:0] G_Z = 2'b10;
    localparam logic [1:0] G_S = 2'b11;

    typedef logic signed [WIDTH:0]  ext_t;
    typedef logic signed [PW-1:0]   wide_t;

    typedef struct packed {
        ext_t re;
        ext_t im;
    } cpx_t;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } res_t;

    localparam wide_t K_H   = wide_t'(INV_SQRT2);
    localparam wide_t RND   = wide_t'(1) <<< (FRAC - 1);
    localparam wide_t MAX_V = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam wide_t MIN_V = ~MAX_V;

    function automatic ext_t sx(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    function automatic logic [WIDTH-1:0] narrow(input wide_t v);
`ifdef QGATE_SAT_EN
        if (v > MAX_V) begin
            return MAX_V[WIDTH-1:0];
        end else if (v < MIN_V) begin
            return MIN_V[WIDTH-1:0];
        end else begin
            return v[WIDTH-1:0];
        end
`else
        return v[WIDTH-1:0];
`endif
    endfunction

    // H scales by 1/sqrt(2) with round-half-up; other gates pass through.
    function automatic logic [WIDTH-1:0] fin(input ext_t s, input logic h);
        wide_t x;
        x = wide_t'(s);
        if (h) begin
            x = (x * K_H + RND) >>> FRAC;
        end
        return narrow(x);
    endfunction

    logic             en;
    logic             acc;

    logic             v1_q, v1_d;
    logic             h1_q, h1_d;
    cpx_t             s0_q, s0_d;
    cpx_t             s1_q, s1_d;

    logic             v2_q, v2_d;
    res_t             r0_q, r0_d;
    res_t             r1_q, r1_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    cpx_t             a0_x;
    cpx_t             a1_x;

    assign en       = ~v2_q | out_ready;
    assign in_ready = en & rst_n;
    assign acc      = in_valid & in_ready;

    assign a0_x.re = sx(a0_re);
    assign a0_x.im = sx(a0_im);
    assign a1_x.re = sx(a1_re);
    assign a1_x.im = sx(a1_im);

    always_comb begin
        v1_d = v1_q;
        h1_d = h1_q;
        s0_d = s0_q;
        s1_d = s1_q;
        if (en) begin
            v1_d = acc;
            if (acc) begin
                h1_d = (gate_sel == G_H);
                unique case (gate_sel)
                    G_H: begin
                        s0_d.re = a0_x.re + a1_x.re;
                        s0_d.im = a0_x.im + a1_x.im;
                        s1_d.re = a0_x.re - a1_x.re;
                        s1_d.im = a0_x.im - a1_x.im;
                    end
                    G_X: begin
                        s0_d = a1_x;
                        s1_d = a0_x;
                    end
                    G_Z: begin
                        s0_d    = a0_x;
                        s1_d.re = -a1_x.re;
                        s1_d.im = -a1_x.im;
                    end
                    G_S: begin
                        s0_d    = a0_x;
                        s1_d.re = -a1_x.im;
                        s1_d.im = a1_x.re;
                    end
                endcase
            end
        end
    end

    always_comb begin
        v2_d = v2_q;
        r0_d = r0_q;
        r1_d = r1_q;
        if (en) begin
            v2_d = v1_q;
            if (v1_q) begin
                r0_d.re = fin(s0_q.re, h1_q);
                r0_d.im = fin(s0_q.im, h1_q);
                r1_d.re = fin(s1_q.re, h1_q);
                r1_d.im = fin(s1_q.im, h1_q);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(v2_q & out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            h1_q  <= 1'b0;
            s0_q  <= '0;
            s1_q  <= '0;
            v2_q  <= 1'b0;
            r0_q  <= '0;
            r1_q  <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            h1_q  <= h1_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            v2_q  <= v2_d;
            r0_q  <= r0_d;
            r1_q  <= r1_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v2_q;
    assign b0_re     = r0_q.re;
    assign b0_im     = r0_q.im;
    assign b1_re     = r1_q.re;
    assign b1_im     = r1_q.im;
    assign op_count  = cnt_q;

endmodule
